// File: rtl/neuron_config_loader.sv
// Byte-serial configuration loader for the delayed-input LIF neuron: collects a frame into a
// shadow image, verifies an XOR checksum, then commits the whole image to the active registers at once.
module neuron_config_loader #(
  parameter int M     = 2,
  parameter int Nbits = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic [7:0]           cfg_data,
  output logic                 cfg_ready,
  input  logic                 run_en,
  output logic [M*Nbits-1:0]   weights,
  output logic [Nbits-1:0]     threshold,
  output logic [Nbits-1:0]     decay,
  output logic [Nbits-1:0]     refractory_period,
  output logic [M*3-1:0]       delay_values,
  output logic [M-1:0]         delays,
  output logic                 neuron_enable,
  output logic                 cfg_loaded,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 cfg_error
);

  localparam int TOTAL  = M*Nbits + 3*Nbits + M*3 + M;
  localparam int NBYTES = (TOTAL + 7) / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam int W_OFF  = 0;
  localparam int TH_OFF = W_OFF + M*Nbits;
  localparam int DE_OFF = TH_OFF + Nbits;
  localparam int RF_OFF = DE_OFF + Nbits;
  localparam int DV_OFF = RF_OFF + Nbits;
  localparam int DL_OFF = DV_OFF + M*3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CSUM
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         xor_q, xor_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [TOTAL-1:0]   active_q, active_d;
  logic               loaded_q, loaded_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // cfg_start wins over any byte offered in the same cycle, in every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    shadow_d = shadow_q;
    active_d = active_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
          xor_d = '0;
        end else if (cfg_valid) begin
          for (int i = 0; i < TOTAL; i++) begin
            if ((i / 8) == int'(cnt_q)) shadow_d[i] = cfg_data[i % 8];
          end
          xor_d = xor_q ^ cfg_data;
          if (cnt_q == CW'(NBYTES - 1)) begin
            state_d = CSUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end else if (cfg_valid) begin
          state_d = IDLE;
          if (cfg_data == xor_q) begin
            active_d = shadow_q;
            loaded_d = 1'b1;
            done_d   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready         = (state_q == LOAD) || (state_q == CSUM);
  assign busy              = (state_q != IDLE);
  assign cfg_loaded        = loaded_q;
  assign cfg_done          = done_q;
  assign cfg_error         = error_q;
  assign neuron_enable     = run_en & loaded_q;

  assign weights           = active_q[W_OFF  +: M*Nbits];
  assign threshold         = active_q[TH_OFF +: Nbits];
  assign decay             = active_q[DE_OFF +: Nbits];
  assign refractory_period = active_q[RF_OFF +: Nbits];
  assign delay_values      = active_q[DV_OFF +: M*3];
  assign delays            = active_q[DL_OFF +: M];

endmodule

// File: tb/tb_neuron_config_loader.sv
// Directed bench for neuron_config_loader: drives config frames with hand-computed images
// and checksums, and compares every active output against constant expectations.
module tb_neuron_config_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready;
  logic       run_en = 1'b0;
  logic [7:0] weights;
  logic [3:0] threshold;
  logic [3:0] decay;
  logic [3:0] refractory_period;
  logic [5:0] delay_values;
  logic [1:0] delays;
  logic       neuron_enable;
  logic       cfg_loaded;
  logic       busy;
  logic       cfg_done;
  logic       cfg_error;

  int vec_count  = 0;
  int miss_count = 0;
  int done_pulses  = 0;
  int error_pulses = 0;
  int gap;

  neuron_config_loader #(.M(2), .Nbits(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_valid         (cfg_valid),
    .cfg_data          (cfg_data),
    .cfg_ready         (cfg_ready),
    .run_en            (run_en),
    .weights           (weights),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .delay_values      (delay_values),
    .delays            (delays),
    .neuron_enable     (neuron_enable),
    .cfg_loaded        (cfg_loaded),
    .busy              (busy),
    .cfg_done          (cfg_done),
    .cfg_error         (cfg_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge so one-cycle pulses are counted exactly once.
  always @(negedge clk) begin
    if (cfg_done)  done_pulses++;
    if (cfg_error) error_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int idle_cycles);
    repeat (idle_cycles) step();
    cfg_valid = 1'b1;
    cfg_data  = b;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic checkConfig(input string tag, input logic [7:0] w, input logic [3:0] th,
                             input logic [3:0] de, input logic [3:0] rf,
                             input logic [5:0] dv, input logic [1:0] dl);
    checkOutput({tag, ".weights"},    32'(weights),           32'(w));
    checkOutput({tag, ".threshold"},  32'(threshold),         32'(th));
    checkOutput({tag, ".decay"},      32'(decay),             32'(de));
    checkOutput({tag, ".refractory"}, 32'(refractory_period), 32'(rf));
    checkOutput({tag, ".delay_vals"}, 32'(delay_values),      32'(dv));
    checkOutput({tag, ".delays"},     32'(delays),            32'(dl));
  endtask

  initial begin
    int d0, e0;

    // Reset state
    #12;
    checkConfig("rst", 8'h00, 4'h0, 4'h0, 4'h0, 6'h00, 2'b00);
    checkOutput("rst.loaded", 32'(cfg_loaded), 32'd0);
    checkOutput("rst.busy",   32'(busy),       32'd0);
    checkOutput("rst.ready",  32'(cfg_ready),  32'd0);
    checkOutput("rst.done",   32'(cfg_done),   32'd0);
    checkOutput("rst.error",  32'(cfg_error),  32'd0);
    #11 rst_n = 1'b1;
    step();

    // Enable is gated before any commit
    run_en = 1'b1;
    #1;
    checkOutput("t3.enable_pre", 32'(neuron_enable), 32'd0);
    step();

    // Test 1: valid frame, image 0x07123CA5
    pulseStart();
    checkOutput("t1.busy",  32'(busy),      32'd1);
    checkOutput("t1.ready", 32'(cfg_ready), 32'd1);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h3C, 0);
    applyStimulus(8'h12, 0);
    checkOutput("t1.no_partial", 32'(weights), 32'h00);
    applyStimulus(8'h07, 0);
    checkOutput("t1.csum_busy", 32'(busy), 32'd1);
    applyStimulus(8'h8C, 0);
    checkOutput("t1.done",   32'(cfg_done),      32'd1);
    checkOutput("t1.error",  32'(cfg_error),     32'd0);
    checkOutput("t1.loaded", 32'(cfg_loaded),    32'd1);
    checkOutput("t3.enable", 32'(neuron_enable), 32'd1);
    checkOutput("t1.idle",   32'(busy),          32'd0);
    checkConfig("t1", 8'hA5, 4'hC, 4'h3, 4'h2, 6'h31, 2'b01);
    step();
    checkOutput("t1.done_1cyc", 32'(cfg_done), 32'd0);

    // Test 2: bad checksum leaves active config alone
    pulseStart();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h8D, 0);
    checkOutput("t2.error",  32'(cfg_error),  32'd1);
    checkOutput("t2.done",   32'(cfg_done),   32'd0);
    checkOutput("t2.loaded", 32'(cfg_loaded), 32'd1);
    checkOutput("t2.busy",   32'(busy),       32'd0);
    checkConfig("t2", 8'hA5, 4'hC, 4'h3, 4'h2, 6'h31, 2'b01);
    step();
    checkOutput("t2.error_1cyc", 32'(cfg_error), 32'd0);

    // Test 4: abort after two bytes, restart with byte offered on the restart cycle
    d0 = done_pulses;
    e0 = error_pulses;
    pulseStart();
    applyStimulus(8'h5A, 0);
    applyStimulus(8'hC3, 0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    pulseStart();
    cfg_valid = 1'b0;
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h04, 0);
    checkConfig("t4.old", 8'hA5, 4'hC, 4'h3, 4'h2, 6'h31, 2'b01);
    applyStimulus(8'h04, 0);
    checkOutput("t4.done", 32'(cfg_done), 32'd1);
    checkConfig("t4", 8'h11, 4'h2, 4'h2, 4'h3, 6'h03, 2'b01);
    step();
    step();
    checkOutput("t4.done_count",  32'(done_pulses - d0),  32'd1);
    checkOutput("t4.error_count", 32'(error_pulses - e0), 32'd0);

    // Test 5: valid in IDLE and on the start cycle, then gapped frame
    cfg_valid = 1'b1;
    cfg_data  = 8'h77;
    step();
    step();
    checkOutput("t5.idle_ready", 32'(cfg_ready), 32'd0);
    pulseStart();
    cfg_valid = 1'b0;
    gap = $urandom_range(0, 5); applyStimulus(8'hA5, gap);
    gap = $urandom_range(0, 5); applyStimulus(8'h3C, gap);
    gap = $urandom_range(0, 5); applyStimulus(8'h12, gap);
    gap = $urandom_range(0, 5); applyStimulus(8'h07, gap);
    repeat (3) step();
    checkOutput("t5.wait_busy", 32'(busy), 32'd1);
    gap = $urandom_range(0, 5); applyStimulus(8'h8C, gap);
    checkOutput("t5.done", 32'(cfg_done), 32'd1);
    checkConfig("t5", 8'hA5, 4'hC, 4'h3, 4'h2, 6'h31, 2'b01);
    step();

    // Test 6: asynchronous reset mid-frame over a committed config
    pulseStart();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    checkConfig("t6", 8'h00, 4'h0, 4'h0, 4'h0, 6'h00, 2'b00);
    checkOutput("t6.busy",   32'(busy),          32'd0);
    checkOutput("t6.loaded", 32'(cfg_loaded),    32'd0);
    checkOutput("t6.enable", 32'(neuron_enable), 32'd0);
    checkOutput("t6.ready",  32'(cfg_ready),     32'd0);
    #10 rst_n = 1'b1;
    step();
    checkOutput("t6.post_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
